// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS display: LFSR tap masks,
// supported width range and a period helper.
package prbs_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  // Entry w holds the 0-based tap positions for a width-w LFSR.
  localparam logic [MAX_WIDTH:0][15:0] TAPS = {
    16'hD008, 16'h6000, 16'h2015, 16'h100D,
    16'h0829, 16'h0500, 16'h0240, 16'h0110,
    16'h00B8, 16'h0060, 16'h0030, 16'h0014,
    16'h000C, 16'h0006, 16'h0000, 16'h0000,
    16'h0000
  };

  function automatic logic [15:0] tap_mask(input int w);
    logic [4:0] idx;
    idx = w[4:0];
    if (w < MIN_WIDTH || w > MAX_WIDTH) return '0;
    return TAPS[idx];
  endfunction

  function automatic int unsigned period(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/hexToSevenSeg.sv
// Hex nibble to active-low seven-segment glyph.
// Bit order {g,f,e,d,c,b,a}.
module hexToSevenSeg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/prbs_hex_display_debounce.sv
// Pushbutton conditioner: 2-flop sync, saturating
// low-time counter, single pulse per press.
module debounce_pulse #(
  parameter int CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_pulse
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          btn_low;

  always_comb begin
    sync_d  = {sync_q[0], i_btn_n};
    btn_low = ~sync_q[1];
    pulse_d = btn_low && (cnt_q == LAST);
    cnt_d   = '0;
    // Parking at SAT keeps a held button from re-firing.
    if (btn_low) begin
      cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/prbs_hex_display.sv
// Fibonacci LFSR with run/step advance and seed load,
// shown on a bank of hex seven-segment digits.
module prbs_hex_display
  import prbs_pkg::*;
#(
  parameter int          WIDTH           = 7,
  parameter int unsigned SEED            = 1,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          PRESCALE_CYCLES = 50000000,
  localparam int         N_DIGITS        = (WIDTH + 3) / 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  input  logic                  i_step_n,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_seed,
  output logic [WIDTH-1:0]      o_value,
  output logic [7*N_DIGITS-1:0] o_seg,
  output logic                  o_wrap
);

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [15:0] TAP_MASK = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAP_W = TAP_MASK[WIDTH-1:0];
  localparam int PW = $clog2(PRESCALE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_CYCLES - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("prbs_hex_display: WIDTH %0d unsupported", WIDTH);
  end
  if (SEED_V == '0) begin : g_bad_seed
    $error("prbs_hex_display: SEED must be non-zero");
  end

  logic [1:0]       run_sync_q, run_sync_d;
  logic [1:0]       load_sync_q, load_sync_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             wrap_q, wrap_d;
  logic             run_s, load_s, pre_en, tick;
  logic             step_pulse, adv;
  logic [WIDTH-1:0] nxt, seed_v;

  debounce_pulse #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_step (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_step_n),
    .o_pulse (step_pulse)
  );

  always_comb begin
    run_sync_d  = {run_sync_q[0], i_run};
    load_sync_d = {load_sync_q[0], i_load};
    run_s  = run_sync_q[1];
    load_s = load_sync_q[1];
    pre_en = run_s & ~load_s;
    tick   = pre_en && (pre_q == PRE_LAST);
    pre_d  = '0;
    if (pre_en && !tick) pre_d = pre_q + 1'b1;
    adv    = run_s ? tick : step_pulse;
    nxt    = {state_q[WIDTH-2:0], ^(state_q & TAP_W)};
    seed_v = (i_seed == '0) ? SEED_V : i_seed;
    state_d = state_q;
    start_d = start_q;
    wrap_d  = 1'b0;
    // Load outranks an advance landing on the same cycle.
    if (load_s) begin
      state_d = seed_v;
      start_d = seed_v;
    end else if (adv) begin
      state_d = nxt;
      wrap_d  = (nxt == start_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_sync_q  <= 2'b00;
      load_sync_q <= 2'b00;
      pre_q       <= '0;
      state_q     <= SEED_V;
      start_q     <= SEED_V;
      wrap_q      <= 1'b0;
    end else begin
      run_sync_q  <= run_sync_d;
      load_sync_q <= load_sync_d;
      pre_q       <= pre_d;
      state_q     <= state_d;
      start_q     <= start_d;
      wrap_q      <= wrap_d;
    end
  end

  logic [4*N_DIGITS-1:0] nibbles;
  assign nibbles = (4*N_DIGITS)'(state_q);

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    hexToSevenSeg u_hex (
      .hex (nibbles[4*k +: 4]),
      .seg (o_seg[7*k +: 7])
    );
  end

  assign o_value = state_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_prbs_hex_display.sv
// Randomised bench for prbs_hex_display with a
// cycle-level behavioural model and literal pins.
module tb_prbs_hex_display;

  localparam int W   = 7;
  localparam int DEB = 4;
  localparam int PRE = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, step_n, load;
  logic [6:0]  seed;
  logic [6:0]  value;
  logic [13:0] seg;
  logic        wrap;

  always #5 clk = ~clk;

  prbs_hex_display #(
    .WIDTH           (W),
    .SEED            (1),
    .DEBOUNCE_CYCLES (DEB),
    .PRESCALE_CYCLES (PRE)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_run    (run),
    .i_step_n (step_n),
    .i_load   (load),
    .i_seed   (seed),
    .o_value  (value),
    .o_seg    (seg),
    .o_wrap   (wrap)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] m_v, m_start;
  logic       m_wrap;
  bit         q_run[$], q_step[$], q_load[$];
  int         m_low, m_pre;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
            7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
            7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  // x^7 + x^6 + 1, shifting towards the MSB
  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 7'h01;
    m_start = 7'h01;
    m_wrap = 1'b0;
    q_run = '{1'b0, 1'b0};
    q_step = '{1'b1, 1'b1};
    q_load = '{1'b0, 1'b0};
    m_low = 0;
    m_pre = 0;
  endtask

  task automatic model_step();
    bit rs, ss, ls, pulse, en, tick, adv;
    rs = q_run.pop_front();
    ss = q_step.pop_front();
    ls = q_load.pop_front();
    q_run.push_back(run);
    q_step.push_back(step_n);
    q_load.push_back(load);
    pulse = (m_low == DEB);
    if (!ss) begin
      if (m_low <= DEB) m_low++;
    end else begin
      m_low = 0;
    end
    en = rs && !ls;
    if (en) m_pre++;
    else m_pre = 0;
    tick = en && (m_pre % PRE == 0);
    adv = rs ? tick : pulse;
    if (ls) begin
      m_v = (seed == 7'h00) ? 7'h01 : seed;
      m_start = m_v;
      m_wrap = 1'b0;
    end else if (adv) begin
      m_v = lfsr_next(m_v);
      m_wrap = (m_v == m_start);
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic compare();
    check("value", value, m_v);
    check("wrap", wrap, m_wrap);
    check("seg", seg, {glyph({1'b0, m_v[6:4]}), glyph(m_v[3:0])});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [6:0] want);
    logic [6:0] prev;
    int lat;
    prev = value;
    lat = 0;
    step_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (lat == 0 && value != prev) lat = i;
    end
    step_n = 1'b1;
    for (int i = 0; i < 6 + int'($urandom_range(0, 4)); i++) cyc();
    check("step_latency", lat, 7);
    check("step_value", value, want);
  endtask

  initial begin
    logic [6:0] prev;
    int changes, wraps, zeros, lat;
    bit pat [8];
    rst_n = 1'b1;
    run = 1'b0;
    step_n = 1'b1;
    load = 1'b0;
    seed = 7'h00;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_value", value, 7'h01);
    check("rst_seg", seg, {7'h40, 7'h79});
    check("rst_wrap", wrap, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seed = 7'($urandom);
      cyc();
    end

    press(7'h02);
    press(7'h04);
    press(7'h08);

    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    prev = value;
    changes = 0;
    for (int i = 0; i < 8; i++) begin
      step_n = pat[i];
      cyc();
      if (value != prev) changes++;
      prev = value;
    end
    step_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (value != prev) changes++;
      prev = value;
    end
    step_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (value != prev) changes++;
      prev = value;
    end
    check("held_advances", changes, 1);
    check("held_value", value, 7'h10);

    sync_reset();
    run = 1'b1;
    prev = value;
    changes = 0;
    wraps = 0;
    zeros = 0;
    for (int i = 0; i < 2 + 127 * PRE; i++) begin
      if ((i % 37) == 0) step_n = 1'($urandom);
      cyc();
      if (value != prev) changes++;
      if (wrap) wraps++;
      if (value == 7'h00) zeros++;
      prev = value;
    end
    step_n = 1'b1;
    check("run_advances", changes, 127);
    check("run_wraps", wraps, 1);
    check("run_zero_seen", zeros, 0);
    check("run_final", value, 7'h01);

    run = 1'b0;
    load = 1'b1;
    seed = 7'h00;
    for (int i = 0; i < 4; i++) cyc();
    check("load_zero_seed", value, 7'h01);
    seed = 7'h55;
    for (int i = 0; i < 4; i++) cyc();
    check("load_55", value, 7'h55);
    check("load_55_seg", seg, {7'h12, 7'h12});

    load = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 30 && (m_pre % PRE) != 7; i++) cyc();
    check("tick_align", m_pre % PRE, 7);
    load = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("load_on_tick", value, 7'h55);
    load = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    check("pre_async_value", value, 7'h2B);

    for (int i = 0; i < int'($urandom_range(2, 6)); i++) cyc();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_value", value, 7'h01);
    check("async_rst_wrap", wrap, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev = value;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (lat == 0 && value != prev) lat = i;
    end
    check("pre_restart", lat, 12);

    for (int i = 0; i < 60; i++) begin
      run = 1'($urandom);
      step_n = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 9) == 0);
      seed = 7'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prbs_hex_display.md
Name: prbs_hex_display

Overview:
- Parametrised PRBS generator driving a bank of seven-segment digits.
- Fibonacci LFSR of configurable width, with two advance modes:
  - free-run at a prescaled rate;
  - single-step on a debounced active-low pushbutton.
- Seed can be loaded from switches; an all-zero lock-up seed is guarded against.
- Top-level board block; decodes the register value onto N_DIGITS displays and flags completion of each full period.

Parameters:
- WIDTH, 7, LFSR width in bits; supported 3..16 (elaboration error otherwise).
- SEED, 1, reset and fallback seed; must be non-zero.
- DEBOUNCE_CYCLES, 500000, stable-low cycles before a step is accepted (10 ms at 50 MHz).
- PRESCALE_CYCLES, 50000000, cycles per advance in run mode (1 Hz at 50 MHz).
- N_DIGITS, (WIDTH+3)/4, derived localparam, not overridable.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_run  in  1  slide switch, 1 = free-run, 0 = step mode; asynchronous to i_clk
- i_step_n  in  1  raw pushbutton, 0 while depressed; asynchronous to i_clk
- i_load  in  1  slide switch, level; while 1 the LFSR holds the loaded seed
- i_seed  in  WIDTH  seed switches
- o_value  out  WIDTH  current LFSR state
- o_seg  out  7*N_DIGITS  segment patterns; digit k occupies [7k+6:7k], digit 0 = least significant nibble
- o_wrap  out  1  one-cycle pulse when the state returns to the period start

Behaviour:
- Clock and reset:
  - One clock (i_clk); reset is asynchronous and active-low (i_rst_n).
  - All flops reset asynchronously.
  - Reset values: o_value = SEED; o_wrap = 0; prescaler = 0; debounce counter = 0; synchronisers = idle (run = 0, step_n = 1, load = 0); period-start register = SEED.
- Input synchronisation: i_run, i_step_n and i_load pass through 2-flop synchronisers before any use. i_seed is sampled only while synchronised load = 1.
- Debouncer:
  - Counter increments while synchronised step_n = 0 and clears when it is 1.
  - A one-cycle step pulse fires on the cycle the counter reaches DEBOUNCE_CYCLES-1.
  - The counter then saturates, so a held button produces exactly one pulse.
  - Release for one or more cycles re-arms it.
- Prescaler:
  - Counts 0..PRESCALE_CYCLES-1 while run = 1; tick fires at the terminal count, then wraps to 0.
  - Held at 0 while run = 0 or load = 1.
- Advance:
  - adv = (run ? tick : step_pulse).
  - The step pulse is ignored in run mode; the tick cannot occur in step mode.
- LFSR:
  - next = {state[WIDTH-2:0], fb}, where fb is the XOR of the tap bits in TAPS[WIDTH] (package).
  - Maximal-length polynomial; period 2^WIDTH-1.
- Priority, evaluated each cycle:
  - load = 1: state <= (i_seed == 0 ? SEED : i_seed); period-start <= the same value; o_wrap <= 0.
  - else if adv: state <= next; o_wrap <= (next == period-start).
  - else: hold; o_wrap <= 0.
- Simultaneous load and adv: load wins and adv is discarded.
- Zero-seed guard: state never becomes 0 in operation.
- Latency:
  - o_value changes on the cycle after adv.
  - o_seg is combinational from o_value (same cycle).
  - Step-mode latency from the button edge is 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Display:
  - Each digit is the nibble value[4k+3:4k], zero-padded at the top for the most significant digit.
  - Encoding matches the existing hex decoder (active-low segments, 0-F glyphs).
- Reset mid-operation: immediate return to reset values; a pending debounce or prescale count is lost.

Decomposition:
- Package prbs_pkg:
  - TAPS table, indexed by WIDTH 3..16, as a 16-bit tap mask;
  - MIN_WIDTH = 3 and MAX_WIDTH = 16;
  - function returning the period 2^WIDTH-1, for bench use.
- Sub-module debounce_pulse (parameter CYCLES): contains the synchroniser, the saturating counter and the pulse output; instantiated once for i_step_n.
- Digit decode reuses the existing hexToSevenSeg, one instance per digit in a generate loop.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, PRESCALE_CYCLES=10, WIDTH=7):
- Reset with i_run=0 -> o_value=7'h01, o_seg digit0 shows "1", digit1 shows "0", o_wrap=0.
- Step mode, 3 clean presses -> o_value sequence 01, 02, 04, 08 (taps 6,5); each update arrives 7 cycles after the press edge.
- Button held 100 cycles, plus a bounce pulse train shorter than 4 cycles -> exactly one advance.
- Run mode for 127*10 cycles -> 127 advances, one o_wrap pulse on the return to 01; o_value never 0.
- i_load=1 with i_seed=7'h00 -> o_value=01; with i_seed=7'h55 -> o_value=55, o_seg shows "55"; load asserted on a tick cycle -> tick discarded, o_value=55.
- i_rst_n asserted asynchronously mid-prescale -> o_value=01 immediately, without waiting for a clock edge; prescaler restarts from 0 on release.
